// File: rtl/npu_pkg.sv
// Shared types for the NPU layer sequencer.
//   seq_state_e : sequencer state encoding
//   LOGIT_W     : width of the signed FC2 logit
package npu_pkg;

  localparam int unsigned LOGIT_W = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_GO,
    S_L1_WAIT,
    S_L2_GO,
    S_L2_WAIT,
    S_FC_GO,
    S_FC_RUN,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/npu_seq_watchdog.sv
// Idle-wait watchdog for the layer sequencer.
//   clk, rst : clock, async active-high reset
//   clr      : zero the counter (takes priority over en)
//   en       : count this cycle
//   sat_c    : counter has reached its all-ones limit (combinational)
module npu_seq_watchdog #(
  parameter int unsigned TMO_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sat_c
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [TMO_W-1:0] cnt;

  // Saturating counter; holds at the limit until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign sat_c = (cnt == CNT_MAX);

endmodule

// File: rtl/npu_layer_seq.sv
// Sequences one NPU inference: per channel a conv layer-1 pass then a
// layer-2 pass (accumulating into the partial-sum buffer), then the FCN
// with its fc1 weight-group stream paced against host writes; captures
// the final logit.
//   host_start/host_abort/host_wgrp : host command pulses
//   conv_trigger/conv_layer/conv_save_done/psum_clear/chan_idx : conv side
//   fcn_start/fcn_fc1_valid/fcn_fc1_next/fcn_done/fcn_logit   : FCN side
//   wgrp_req/busy/done/err/result : status back to the host decode
module npu_layer_seq
  import npu_pkg::*;
#(
  parameter int unsigned CHAN       = 10,
  parameter int unsigned FC1_GROUPS = 33,
  parameter int unsigned TMO_W      = 16,
  localparam int unsigned CHAN_W    = (CHAN > 1) ? $clog2(CHAN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_start,
  input  logic                      host_abort,
  input  logic                      host_wgrp,
  output logic                      conv_trigger,
  output logic                      conv_layer,
  input  logic                      conv_save_done,
  output logic                      psum_clear,
  output logic [CHAN_W-1:0]         chan_idx,
  output logic                      fcn_start,
  input  logic                      fcn_fc1_valid,
  output logic                      fcn_fc1_next,
  input  logic                      fcn_done,
  input  logic signed [LOGIT_W-1:0] fcn_logit,
  output logic                      wgrp_req,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic signed [LOGIT_W-1:0] result
);

  localparam int unsigned GRP_W = $clog2(FC1_GROUPS + 1);
  localparam logic [GRP_W-1:0]  GRP_MAX  = GRP_W'(FC1_GROUPS);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHAN - 1);

  seq_state_e       state;
  logic [GRP_W-1:0] grp_cnt;

  logic wd_counting_c;
  logic wd_progress_c;
  logic wd_clr_c;
  logic wd_en_c;
  logic wd_sat_c;
  logic wgrp_take_c;

  assign wgrp_take_c = host_wgrp && wgrp_req;

  // Watchdog runs only in the wait states; GO/IDLE/DONE clear it, so every
  // state change restarts the count. In FC_RUN a pending host group is not
  // an idle wait on the datapath, so counting pauses while wgrp_req=1.
  always_comb begin
    wd_counting_c = (state == S_L1_WAIT) || (state == S_L2_WAIT) || (state == S_FC_RUN);
    wd_progress_c = 1'b0;
    if ((state == S_L1_WAIT) || (state == S_L2_WAIT)) begin
      wd_progress_c = conv_save_done;
    end else if (state == S_FC_RUN) begin
      wd_progress_c = wgrp_take_c || fcn_fc1_valid || fcn_done;
    end
    wd_clr_c = !wd_counting_c || wd_progress_c || host_abort;
    wd_en_c  = wd_counting_c && !((state == S_FC_RUN) && wgrp_req);
  end

  npu_seq_watchdog #(
    .TMO_W (TMO_W)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr_c),
    .en    (wd_en_c),
    .sat_c (wd_sat_c)
  );

  // Sequencer FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      grp_cnt      <= '0;
      conv_trigger <= 1'b0;
      conv_layer   <= 1'b0;
      psum_clear   <= 1'b0;
      chan_idx     <= '0;
      fcn_start    <= 1'b0;
      fcn_fc1_next <= 1'b0;
      wgrp_req     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
    end else begin
      conv_trigger <= 1'b0;
      psum_clear   <= 1'b0;
      fcn_start    <= 1'b0;
      fcn_fc1_next <= 1'b0;
      done         <= 1'b0;

      if (host_abort) begin
        state    <= S_IDLE;
        wgrp_req <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (host_start) begin
              psum_clear <= 1'b1;
              chan_idx   <= '0;
              err        <= 1'b0;
              busy       <= 1'b1;
              state      <= S_L1_GO;
            end
          end

          S_L1_GO: begin
            conv_layer   <= 1'b0;
            conv_trigger <= 1'b1;
            state        <= S_L1_WAIT;
          end

          S_L1_WAIT: begin
            if (conv_save_done) begin
              state <= S_L2_GO;
            end else if (wd_sat_c) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end

          S_L2_GO: begin
            conv_layer   <= 1'b1;
            conv_trigger <= 1'b1;
            state        <= S_L2_WAIT;
          end

          S_L2_WAIT: begin
            if (conv_save_done) begin
              if (chan_idx == CHAN_LAST) begin
                state <= S_FC_GO;
              end else begin
                chan_idx <= chan_idx + CHAN_W'(1);
                state    <= S_L1_GO;
              end
            end else if (wd_sat_c) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end

          S_FC_GO: begin
            fcn_start <= 1'b1;
            grp_cnt   <= '0;
            wgrp_req  <= 1'b1;
            state     <= S_FC_RUN;
          end

          S_FC_RUN: begin
            if (wgrp_take_c && (grp_cnt == GRP_MAX)) begin
              // Host pushed one group more than the FCN can consume.
              err      <= 1'b1;
              wgrp_req <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else if (fcn_done) begin
              result   <= fcn_logit;
              done     <= 1'b1;
              wgrp_req <= 1'b0;
              state    <= S_DONE;
            end else if (wd_sat_c) begin
              err      <= 1'b1;
              wgrp_req <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              if (wgrp_take_c) begin
                fcn_fc1_next <= 1'b1;
                grp_cnt      <= grp_cnt + GRP_W'(1);
                wgrp_req     <= 1'b0;
              end
              // A new request from the FCN overrides the clear above.
              if (fcn_fc1_valid) begin
                wgrp_req <= 1'b1;
              end
            end
          end

          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_layer_seq.sv
// Self-checking bench for npu_layer_seq (CHAN=2, FC1_GROUPS=3, TMO_W=4).
module tb_npu_layer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_start = 1'b0;
  logic        host_abort = 1'b0;
  logic        host_wgrp = 1'b0;
  logic        conv_trigger;
  logic        conv_layer;
  logic        conv_save_done = 1'b0;
  logic        psum_clear;
  logic [0:0]  chan_idx;
  logic        fcn_start;
  logic        fcn_fc1_valid = 1'b0;
  logic        fcn_fc1_next;
  logic        fcn_done = 1'b0;
  logic signed [23:0] fcn_logit = '0;
  logic        wgrp_req;
  logic        busy;
  logic        done;
  logic        err;
  logic signed [23:0] result;

  int errors = 0;
  int checks = 0;

  npu_layer_seq #(
    .CHAN       (2),
    .FC1_GROUPS (3),
    .TMO_W      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_start     (host_start),
    .host_abort     (host_abort),
    .host_wgrp      (host_wgrp),
    .conv_trigger   (conv_trigger),
    .conv_layer     (conv_layer),
    .conv_save_done (conv_save_done),
    .psum_clear     (psum_clear),
    .chan_idx       (chan_idx),
    .fcn_start      (fcn_start),
    .fcn_fc1_valid  (fcn_fc1_valid),
    .fcn_fc1_next   (fcn_fc1_next),
    .fcn_done       (fcn_done),
    .fcn_logit      (fcn_logit),
    .wgrp_req       (wgrp_req),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .result         (result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        wgrp;
    logic        save;
    logic        valid;
    logic        fdone;
    logic [23:0] logit;
  } in_t;

  typedef struct packed {
    logic        trig;
    logic        layer;
    logic        pclr;
    logic        chan;
    logic        fstart;
    logic        fnext;
    logic        wreq;
    logic        busy;
    logic        done;
    logic        err;
    logic [23:0] result;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic [4:0] ins, input logic [23:0] logit,
                              input logic [9:0] outs, input logic [23:0] res);
    vec_t v;
    v.i = {ins, logit};
    v.o = {outs, res};
    return v;
  endfunction

  function automatic out_t cur();
    out_t o;
    o = {conv_trigger, conv_layer, psum_clear, chan_idx, fcn_start, fcn_fc1_next,
         wgrp_req, busy, done, err, result};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    host_start = 1'b1; tick(); host_start = 1'b0;
  endtask

  task automatic pulse_abort();
    host_abort = 1'b1; tick(); host_abort = 1'b0;
  endtask

  task automatic pulse_wgrp();
    host_wgrp = 1'b1; tick(); host_wgrp = 1'b0;
  endtask

  task automatic pulse_valid();
    fcn_fc1_valid = 1'b1; tick(); fcn_fc1_valid = 1'b0;
  endtask

  task automatic wait_trig(input string name);
    for (int i = 0; i < 40 && conv_trigger !== 1'b1; i++) tick();
    chk(name, 64'(conv_trigger), 64'd1);
  endtask

  task automatic wait_fstart(input string name);
    for (int i = 0; i < 40 && fcn_start !== 1'b1; i++) tick();
    chk(name, 64'(fcn_start), 64'd1);
  endtask

  // Answer each conv trigger with a save-done pulse.
  task automatic run_conv(input int passes);
    for (int p = 0; p < passes; p++) begin
      wait_trig($sformatf("conv_trig%0d", p));
      conv_save_done = 1'b1; tick(); conv_save_done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit ok;

    // inputs: start wgrp save valid fdone
    // outputs: trig layer pclr chan fstart fnext wreq busy done err
    vecs[0]  = mk(5'b10000, 24'h0,      10'b0010000100, 24'h0);
    vecs[1]  = mk(5'b00000, 24'h0,      10'b1000000100, 24'h0);
    vecs[2]  = mk(5'b00100, 24'h0,      10'b0000000100, 24'h0);
    vecs[3]  = mk(5'b00000, 24'h0,      10'b1100000100, 24'h0);
    vecs[4]  = mk(5'b00100, 24'h0,      10'b0101000100, 24'h0);
    vecs[5]  = mk(5'b00000, 24'h0,      10'b1001000100, 24'h0);
    vecs[6]  = mk(5'b00100, 24'h0,      10'b0001000100, 24'h0);
    vecs[7]  = mk(5'b00000, 24'h0,      10'b1101000100, 24'h0);
    vecs[8]  = mk(5'b00100, 24'h0,      10'b0101000100, 24'h0);
    vecs[9]  = mk(5'b00000, 24'h0,      10'b0101101100, 24'h0);
    vecs[10] = mk(5'b01000, 24'h0,      10'b0101010100, 24'h0);
    vecs[11] = mk(5'b00010, 24'h0,      10'b0101001100, 24'h0);
    vecs[12] = mk(5'b01000, 24'h0,      10'b0101010100, 24'h0);
    vecs[13] = mk(5'b00010, 24'h0,      10'b0101001100, 24'h0);
    vecs[14] = mk(5'b01010, 24'h0,      10'b0101011100, 24'h0);
    vecs[15] = mk(5'b00001, 24'hFFFFFB, 10'b0101000110, 24'hFFFFFB);
    vecs[16] = mk(5'b01000, 24'h0,      10'b0101000000, 24'hFFFFFB);

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_state", 64'(cur()), 64'd0);

    // Full run, cycle by cycle.
    for (int k = 0; k < 17; k++) begin
      host_start     = vecs[k].i.start;
      host_wgrp      = vecs[k].i.wgrp;
      conv_save_done = vecs[k].i.save;
      fcn_fc1_valid  = vecs[k].i.valid;
      fcn_done       = vecs[k].i.fdone;
      fcn_logit      = vecs[k].i.logit;
      tick();
      chk($sformatf("vec%0d", k), 64'(cur()), 64'(vecs[k].o));
    end
    {host_start, host_wgrp, conv_save_done, fcn_fc1_valid, fcn_done} = '0;
    fcn_logit = '0;

    // Back-pressure: request held for 20 cycles while the host is slow.
    pulse_start();
    run_conv(4);
    wait_fstart("bp_fstart");
    chk("bp_wreq_init", 64'(wgrp_req), 64'd1);
    pulse_wgrp();
    chk("bp_next1", 64'(fcn_fc1_next), 64'd1);
    pulse_valid();
    chk("bp_wreq_up", 64'(wgrp_req), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wgrp_req !== 1'b1 || fcn_fc1_next !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    chk("bp_hold", 64'(ok), 64'd1);
    pulse_wgrp();
    chk("bp_next2", 64'(fcn_fc1_next), 64'd1);
    tick();
    chk("bp_next2_pulse", 64'(fcn_fc1_next), 64'd0);
    fcn_logit = 24'sd100;
    fcn_done = 1'b1; tick(); fcn_done = 1'b0;
    chk("bp_done", 64'({done, result}), 64'({1'b1, 24'd100}));
    tick();
    chk("bp_idle", 64'({busy, done}), 64'd0);

    // Spurious host group and overrun.
    pulse_start();
    run_conv(4);
    wait_fstart("ov_fstart");
    pulse_wgrp();
    chk("ov_next1", 64'(fcn_fc1_next), 64'd1);
    pulse_wgrp();
    chk("ov_spurious", 64'({fcn_fc1_next, wgrp_req}), 64'd0);
    pulse_valid();
    pulse_wgrp();
    chk("ov_next2", 64'(fcn_fc1_next), 64'd1);
    pulse_valid();
    pulse_wgrp();
    chk("ov_next3", 64'(fcn_fc1_next), 64'd1);
    pulse_valid();
    chk("ov_wreq", 64'(wgrp_req), 64'd1);
    pulse_wgrp();
    chk("ov_err", 64'({err, busy, fcn_fc1_next, wgrp_req}), 64'b1000);
    chk("ov_result_kept", 64'(result), 64'd100);

    // Abort in layer-2 wait of channel 1, then restart from channel 0.
    pulse_start();
    chk("ab_start_clr_err", 64'({err, busy}), 64'b01);
    run_conv(3);
    wait_trig("ab_l2_trig");
    chk("ab_l2_ch1", 64'({conv_layer, chan_idx}), 64'b11);
    tick();
    pulse_abort();
    chk("ab_idle", 64'({busy, wgrp_req, done}), 64'd0);
    chk("ab_result_kept", 64'(result), 64'd100);
    pulse_start();
    wait_trig("ab_restart_trig");
    chk("ab_restart_ch0", 64'({conv_layer, chan_idx}), 64'b00);
    pulse_abort();

    // Watchdog on a missing conv_save_done.
    pulse_start();
    wait_trig("wd_trig");
    for (int i = 0; i < 15; i++) tick();
    chk("wd_early", 64'({err, busy}), 64'b01);
    tick();
    chk("wd_fire", 64'({err, busy}), 64'b10);
    pulse_start();
    chk("wd_restart_clr", 64'({err, busy}), 64'b01);
    pulse_abort();

    // Start while busy is ignored; async reset in FC_RUN.
    pulse_start();
    chk("sb_pclr", 64'(psum_clear), 64'd1);
    tick();
    chk("sb_trig", 64'(conv_trigger), 64'd1);
    pulse_start();
    chk("sb_ignored", 64'({psum_clear, busy, conv_trigger}), 64'b010);
    conv_save_done = 1'b1; tick(); conv_save_done = 1'b0;
    run_conv(3);
    wait_fstart("rs_fstart");
    pulse_wgrp();
    chk("rs_next", 64'(fcn_fc1_next), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async", 64'(cur()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fcn_logit = 24'sd7;
    fcn_done = 1'b1; tick(); fcn_done = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || result !== 24'sd0) ok = 1'b0;
      tick();
    end
    chk("rs_no_done", 64'(ok), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
